// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
//
// Shares the single UART TX byte stream between the echo byte stream and
// ALU result frames. Once a source is granted it owns the stream until its
// packet ends, so bytes from the two sources never interleave. A result
// frame is captured as one wide word and sent as a 4-byte header
// (opcode, 0x00, total length LSB, 0x00) followed by n result bytes, LSB
// first. Total length counts the header: 4 + n.
//
// Optional feature macro: UART_TX_ARB_RR_EN
//   defined   -> round-robin tie-break (source that did not own the last
//                packet wins a simultaneous request)
//   undefined -> fixed priority, echo wins ties
//
// Handshake: every byte interface is valid/ready. A byte moves on a cycle
// where valid and ready are both high; a raised valid is held, with its data
// stable, until that happens.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   echo_data_i/valid_i/last_i, echo_ready_o   echo byte stream
//   res_data_i, res_opcode_i, res_bytes_i,
//   res_valid_i, res_ready_o                   result word (one-shot capture)
//   data_o, valid_o, ready_i                   byte stream to the UART TX
//   dbg_state_o       FSM state (0 IDLE, 1 ECHO, 2 HDR, 3 DATA)
//   dbg_last_grant_o  owner of the last packet (0 echo, 1 result)
module uart_tx_arbiter #(
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       echo_data_i,
  input  logic             echo_valid_i,
  input  logic             echo_last_i,
  output logic             echo_ready_o,
  input  logic [RES_W-1:0] res_data_i,
  input  logic [7:0]       res_opcode_i,
  input  logic [3:0]       res_bytes_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       dbg_state_o,
  output logic             dbg_last_grant_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ECHO = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  localparam logic LG_ECHO = 1'b0;
  localparam logic LG_RES  = 1'b1;

  localparam logic [3:0] NB = 4'(RES_W / 8);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [7:0]       opc_q, opc_d;
  logic [3:0]       n_q, n_d;

  logic             tie_to_res;
  logic             grant_res;
  logic [3:0]       n_clamped;
  logic             xfer;

`ifdef UART_TX_ARB_RR_EN
  assign tie_to_res = (last_grant_q == LG_ECHO);
`else
  assign tie_to_res = 1'b0;
`endif

  assign grant_res = res_valid_i && (!echo_valid_i || tie_to_res);
  // Zero or oversize byte counts mean "send the whole word".
  assign n_clamped = ((res_bytes_i == 4'd0) || (res_bytes_i > NB)) ? NB : res_bytes_i;
  assign xfer      = valid_o && ready_i;

  assign dbg_state_o      = state_q;
  assign dbg_last_grant_o = last_grant_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    opc_d        = opc_q;
    n_d          = n_q;
    data_o       = 8'h00;
    valid_o      = 1'b0;
    echo_ready_o = 1'b0;
    res_ready_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_res) begin
          res_ready_o = 1'b1;
          res_d       = res_data_i;
          opc_d       = res_opcode_i;
          n_d         = n_clamped;
          cnt_d       = 4'd0;
          state_d     = S_HDR;
        end else if (echo_valid_i) begin
          state_d = S_ECHO;
        end
      end

      // Pure combinational pass-through; the echo source sees the UART's ready.
      S_ECHO: begin
        data_o       = echo_data_i;
        valid_o      = echo_valid_i;
        echo_ready_o = ready_i;
        if (xfer && echo_last_i) begin
          state_d      = S_IDLE;
          last_grant_d = LG_ECHO;
        end
      end

      // Header bytes depend only on registered state, never on ready_i.
      S_HDR: begin
        valid_o = 1'b1;
        case (cnt_q[1:0])
          2'd0:    data_o = opc_q;
          2'd2:    data_o = {4'd0, n_q} + 8'd4;
          default: data_o = 8'h00;
        endcase
        if (xfer) begin
          if (cnt_q == 4'd3) begin
            cnt_d   = 4'd0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        valid_o = 1'b1;
        if (cnt_q < NB) data_o = res_q[8*cnt_q +: 8];
        if (xfer) begin
          if (cnt_q == n_q - 4'd1) begin
            cnt_d        = 4'd0;
            state_d      = S_IDLE;
            last_grant_d = LG_RES;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LG_RES;
      cnt_q        <= 4'd0;
      res_q        <= '0;
      opc_q        <= 8'h00;
      n_q          <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      opc_q        <= opc_d;
      n_q          <= n_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ECHO = 2'd1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  echo_data_i;
  logic        echo_valid_i;
  logic        echo_last_i;
  logic        echo_ready_o;
  logic [63:0] res_data_i;
  logic [7:0]  res_opcode_i;
  logic [3:0]  res_bytes_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  dbg_state_o;
  logic        dbg_last_grant_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.RES_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .echo_data_i      (echo_data_i),
    .echo_valid_i     (echo_valid_i),
    .echo_last_i      (echo_last_i),
    .echo_ready_o     (echo_ready_o),
    .res_data_i       (res_data_i),
    .res_opcode_i     (res_opcode_i),
    .res_bytes_i      (res_bytes_i),
    .res_valid_i      (res_valid_i),
    .res_ready_o      (res_ready_o),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .dbg_state_o      (dbg_state_o),
    .dbg_last_grant_o (dbg_last_grant_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Every byte accepted by the UART side must be the next expected byte.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
      else                   check("tx_byte", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Counts cycles spent outside IDLE, bounded by budget.
  task automatic run_until_idle(input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state_o == S_IDLE) break;
      cycles++;
    end
  endtask

  // Requests a result and checks the full packet; exp_n is the hand-clamped count.
  task automatic send_result(input string tag, input logic [7:0] opc, input logic [3:0] nb,
                             input logic [63:0] data, input int exp_n);
    int cyc;
    res_opcode_i = opc;
    res_bytes_i  = nb;
    res_data_i   = data;
    res_valid_i  = 1'b1;
    ready_i      = 1'b1;
    @(negedge clk);
    check({tag, "_res_ready"}, {31'd0, res_ready_o}, 32'd1);
    exp_q.push_back(opc);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(4 + exp_n));
    exp_q.push_back(8'h00);
    for (int i = 0; i < exp_n; i++) exp_q.push_back(data[8*i +: 8]);
    next_cycle();
    res_valid_i = 1'b0;
    run_until_idle(40, cyc);
    check({tag, "_pkt_cycles"}, cyc, 4 + exp_n);
    check({tag, "_res_ready_idle"}, {31'd0, res_ready_o}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Both sources request in IDLE; single-byte echo vs 1-byte result.
  task automatic tie_round(input string tag, input logic exp_res_wins, input logic [7:0] eb);
    int cyc;
    echo_data_i  = eb;
    echo_last_i  = 1'b1;
    echo_valid_i = 1'b1;
    res_opcode_i = 8'h05;
    res_bytes_i  = 4'd1;
    res_data_i   = 64'h77;
    res_valid_i  = 1'b1;
    ready_i      = 1'b1;
    @(negedge clk);
    check({tag, "_grant_res"}, {31'd0, res_ready_o}, {31'd0, exp_res_wins});
    check({tag, "_idle_valid"}, {31'd0, valid_o}, 32'd0);
    if (exp_res_wins) begin
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h77);
      next_cycle();
      res_valid_i  = 1'b0;
      echo_valid_i = 1'b0;
      run_until_idle(20, cyc);
      check({tag, "_res_cycles"}, cyc, 5);
    end else begin
      exp_q.push_back(eb);
      next_cycle();
      @(negedge clk);
      // res_valid_i is still high: the echo packet must not be interrupted.
      check({tag, "_echo_state"}, {30'd0, dbg_state_o}, {30'd0, S_ECHO});
      check({tag, "_no_res_ready"}, {31'd0, res_ready_o}, 32'd0);
      next_cycle();
      echo_valid_i = 1'b0;
      res_valid_i  = 1'b0;
      @(negedge clk);
      check({tag, "_back_idle"}, {30'd0, dbg_state_o}, {30'd0, S_IDLE});
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    next_cycle();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cyc;
    rst          = 1'b1;
    echo_data_i  = 8'h00;
    echo_valid_i = 1'b0;
    echo_last_i  = 1'b0;
    res_data_i   = 64'd0;
    res_opcode_i = 8'h00;
    res_bytes_i  = 4'd0;
    res_valid_i  = 1'b0;
    ready_i      = 1'b1;

    // Reset state
    next_cycle();
    @(negedge clk);
    check("rst_state", {30'd0, dbg_state_o}, {30'd0, S_IDLE});
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_echo_ready", {31'd0, echo_ready_o}, 32'd0);
    check("rst_res_ready", {31'd0, res_ready_o}, 32'd0);
    check("rst_last_grant", {31'd0, dbg_last_grant_o}, 32'd1);
    next_cycle();
    rst = 1'b0;

    // ADD result: 02 00 08 00 EF BE AD DE
    send_result("add", 8'h02, 4'd4, 64'h0000_0000_DEAD_BEEF, 4);
    next_cycle();

    // Echo A1 A2 A3 through the combinational path
    echo_data_i  = 8'hA1;
    echo_last_i  = 1'b0;
    echo_valid_i = 1'b1;
    @(negedge clk);
    check("echo_arb_valid", {31'd0, valid_o}, 32'd0);
    check("echo_arb_ready", {31'd0, echo_ready_o}, 32'd0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    next_cycle();
    @(negedge clk);
    check("echo_ready_a1", {31'd0, echo_ready_o}, 32'd1);
    next_cycle();
    echo_data_i = 8'hA2;
    @(negedge clk);
    check("echo_pass_a2", {24'd0, data_o}, 32'hA2);
    next_cycle();
    echo_data_i = 8'hA3;
    echo_last_i = 1'b1;
    @(negedge clk);
    next_cycle();
    echo_valid_i = 1'b0;
    echo_last_i  = 1'b0;
    @(negedge clk);
    check("echo_ready_after", {31'd0, echo_ready_o}, 32'd0);
    check("echo_end_state", {30'd0, dbg_state_o}, {30'd0, S_IDLE});
    check("echo_last_grant", {31'd0, dbg_last_grant_o}, 32'd0);
    check("echo_drained", exp_q.size(), 0);
    next_cycle();

    // res_bytes_i = 0 and oversize both clamp to 8 bytes
    send_result("len0", 8'h03, 4'd0, 64'h1122_3344_5566_7788, 8);
    next_cycle();
    send_result("len15", 8'h04, 4'd15, 64'h0102_0304_0506_0708, 8);
    next_cycle();

    // Stall during HDR: ready 1,0,0,1
    res_opcode_i = 8'h04;
    res_bytes_i  = 4'd2;
    res_data_i   = 64'hCAFE;
    res_valid_i  = 1'b1;
    @(negedge clk);
    check("stall_res_ready", {31'd0, res_ready_o}, 32'd1);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hCA);
    next_cycle();
    res_valid_i = 1'b0;
    @(negedge clk);
    next_cycle();
    ready_i = 1'b0;
    @(negedge clk);
    check("stall1_valid", {31'd0, valid_o}, 32'd1);
    check("stall1_data", {24'd0, data_o}, 32'h00);
    next_cycle();
    @(negedge clk);
    check("stall2_valid", {31'd0, valid_o}, 32'd1);
    check("stall2_data", {24'd0, data_o}, 32'h00);
    next_cycle();
    ready_i = 1'b1;
    @(negedge clk);
    run_until_idle(20, cyc);
    check("stall_rest_cycles", cyc, 4);
    check("stall_drained", exp_q.size(), 0);
    next_cycle();

    // Tie-break, starting from reset (last_grant = result)
    do_reset();
    tie_round("tie1", 1'b0, 8'hB1);
`ifdef UART_TX_ARB_RR_EN
    tie_round("tie2", 1'b1, 8'hB2);
    check("tie_last_grant", {31'd0, dbg_last_grant_o}, 32'd1);
`else
    tie_round("tie2", 1'b0, 8'hB2);
    check("tie_last_grant", {31'd0, dbg_last_grant_o}, 32'd0);
`endif

    // Reset during DATA byte 2, then a fresh packet
    res_opcode_i = 8'h06;
    res_bytes_i  = 4'd4;
    res_data_i   = 64'h4433_2211;
    res_valid_i  = 1'b1;
    @(negedge clk);
    check("rstmid_res_ready", {31'd0, res_ready_o}, 32'd1);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    next_cycle();
    res_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_byte2", {24'd0, data_o}, 32'h33);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", {31'd0, valid_o}, 32'd0);
    check("rstmid_state", {30'd0, dbg_state_o}, {30'd0, S_IDLE});
    check("rstmid_drained", exp_q.size(), 0);
    next_cycle();
    send_result("after_rst", 8'h07, 4'd1, 64'h5A, 1);

    next_cycle();
    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
